// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, fetches over a req/gnt/rvalid port
// with one request outstanding, and buffers {inst, pc_plus4} pairs in a FIFO.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [29:0] RESET_PC = 30'h100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [29:0] redirect_pc,
    input  logic        stall,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [29:0] out_pc_plus4,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL    = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DISCARD
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [29:0]   pc_reg;
    logic [29:0]   req_addr;
    logic [PW:0]   count;
    logic [PW:0]   count_next;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          granted;

    logic [31:0]   inst_mem [DEPTH];
    logic [29:0]   pcp4_mem [DEPTH];

    assign out_valid    = (count != '0);
    assign out_inst     = out_valid ? inst_mem[rd_ptr] : '0;
    assign out_pc_plus4 = out_valid ? pcp4_mem[rd_ptr] : '0;
    assign imem_req     = (state == REQ);
    assign imem_addr    = pc_reg;
    assign granted      = (state == REQ) && imem_gnt;

    // Redirect beats both push and pop; a request only issues with a free slot,
    // so a push from WAIT can never overflow the FIFO.
    always_comb begin
        push       = (state == WAIT) && imem_rvalid && !redirect;
        pop        = out_valid && !stall && !redirect;
        count_next = count + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
        state_next = state;
        case (state)
            IDLE: begin
                if (redirect || count < FULL) state_next = REQ;
            end
            REQ: begin
                if (imem_gnt) state_next = redirect ? DISCARD : WAIT;
            end
            WAIT: begin
                if (redirect)         state_next = imem_rvalid ? REQ : DISCARD;
                else if (imem_rvalid) state_next = (count_next < FULL) ? REQ : IDLE;
            end
            DISCARD: begin
                if (imem_rvalid) state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            pc_reg   <= RESET_PC;
            req_addr <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state <= state_next;
            if (granted) req_addr <= pc_reg;
            if (redirect) begin
                pc_reg <= redirect_pc;
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (granted) pc_reg <= pc_reg + 30'd1;
                count <= count_next;
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Entry storage needs no reset; out_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= imem_rdata;
            pcp4_mem[wr_ptr] <= req_addr + 30'd1;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: acts as the instruction memory and
// compares the DUT against a queue-based model of the fetch stream.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [29:0] RESET_PC = 30'h100000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect = 1'b0;
    logic [29:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [29:0] out_pc_plus4;
    logic        imem_req;
    logic [29:0] imem_addr;

    int checks = 0;
    int errors = 0;

    // Model state: delivered entries in order, next fetch address, and the
    // single outstanding memory transaction (stale once a redirect overtakes it).
    logic [61:0] q[$];
    logic [29:0] mpc = RESET_PC;
    logic [29:0] req_addr_m = '0;
    logic [29:0] next_pcp4 = RESET_PC + 30'd1;
    bit          outstanding = 1'b0;
    bit          stale = 1'b0;
    bit          expect_req = 1'b0;
    bit          manual = 1'b0;
    int          cnt = 0;
    int          gnt_pct = 100;
    int          lat_max = 1;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .stall        (stall),
        .out_valid    (out_valid),
        .out_inst     (out_inst),
        .out_pc_plus4 (out_pc_plus4),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock; the memory side is driven randomly unless manual.
    task automatic tick();
        logic        req_s;
        logic        gnt_s;
        logic        rv_s;
        logic [29:0] addr_s;
        logic [31:0] data_s;
        if (!manual) begin
            imem_gnt    = imem_req && ($urandom_range(99) < gnt_pct);
            imem_rvalid = outstanding && (cnt <= 1);
            imem_rdata  = $urandom();
        end
        req_s  = imem_req;
        gnt_s  = imem_gnt;
        rv_s   = imem_rvalid;
        addr_s = imem_addr;
        data_s = imem_rdata;
        @(posedge clk);
        #1;
        if (!reset) begin
            q.delete();
            mpc         = RESET_PC;
            outstanding = 1'b0;
            expect_req  = 1'b0;
        end else begin
            if (q.size() != 0 && !stall && !redirect) void'(q.pop_front());
            if (outstanding && rv_s) begin
                if (!stale && !redirect) q.push_back({data_s, req_addr_m + 30'd1});
                outstanding = 1'b0;
            end else if (outstanding) begin
                cnt--;
            end
            if (req_s && gnt_s) begin
                outstanding = 1'b1;
                stale       = 1'b0;
                req_addr_m  = addr_s;
                mpc         = mpc + 30'd1;
                cnt         = $urandom_range(lat_max, 1);
            end
            if (redirect) begin
                q.delete();
                mpc   = redirect_pc;
                stale = 1'b1;
            end
            expect_req = redirect && !outstanding;
        end
    endtask

    // Run in automatic mode with grants withheld until the DUT sits in REQ.
    task automatic settle();
        int n = 0;
        manual   = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        gnt_pct  = 0;
        lat_max  = 1;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL settle: imem_req=%b expected 1 within 20 cycles", imem_req);
        end
    endtask

    task automatic test_reset();
        manual      = 1'b1;
        reset       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        tick();
        tick();
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
        if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
        if (out_inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst: got %h expected 0", out_inst); end
        if (out_pc_plus4 !== 30'h0) begin errors++; $display("[TB] FAIL reset_pcp4: got %h expected 0", out_pc_plus4); end
        reset = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 30'h100000) begin
            errors++;
            $display("[TB] FAIL reset_first_req: got req=%b addr=%h expected req=1 addr=100000", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        int pops = 0;
        manual  = 1'b0;
        stall   = 1'b0;
        gnt_pct = 100;
        lat_max = 1;
        repeat (24) begin
            if (out_valid) begin
                checks++;
                if (out_pc_plus4 !== next_pcp4) begin
                    errors++;
                    $display("[TB] FAIL seq_order: got pcp4=%h expected %h", out_pc_plus4, next_pcp4);
                end
                next_pcp4 = next_pcp4 + 30'd1;
                pops++;
            end
            tick();
            checks++;
            if (out_valid !== (q.size() != 0)) begin
                errors++;
                $display("[TB] FAIL seq_valid: got %b expected %b", out_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                checks++;
                if ({out_inst, out_pc_plus4} !== q[0]) begin
                    errors++;
                    $display("[TB] FAIL seq_head: got %h/%h expected %h/%h", out_inst, out_pc_plus4, q[0][61:30], q[0][29:0]);
                end
            end
            if (imem_req) begin
                checks++;
                if (imem_addr !== mpc) begin
                    errors++;
                    $display("[TB] FAIL seq_addr: got %h expected %h", imem_addr, mpc);
                end
            end
        end
        checks++;
        if (pops < 10) begin
            errors++;
            $display("[TB] FAIL seq_throughput: got %0d pops expected at least 10", pops);
        end
    endtask

    task automatic test_stall();
        bit saw_req = 1'b0;
        manual = 1'b0;
        stall  = 1'b1;
        repeat (12) tick();
        checks += 2;
        if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req: got %b expected 0", imem_req); end
        if (q.size() != DEPTH || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_full: got valid=%b model_count=%0d expected valid=1 count=%0d", out_valid, q.size(), DEPTH);
        end
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc_plus4 !== next_pcp4) begin
                errors++;
                $display("[TB] FAIL stall_drain%0d: got valid=%b pcp4=%h expected 1/%h", i, out_valid, out_pc_plus4, next_pcp4);
            end
            next_pcp4 = next_pcp4 + 30'd1;
            tick();
            if (imem_req) saw_req = 1'b1;
        end
        checks++;
        if (!saw_req) begin errors++; $display("[TB] FAIL stall_resume: got no request expected fetch to resume"); end
    endtask

    task automatic test_redirect_wait();
        settle();
        manual      = 1'b1;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        tick();
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 30'h100040;
        tick();
        redirect = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rdw_flush: got valid=%b expected 0", out_valid); end
        if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rdw_discard: got req=%b expected 0", imem_req); end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEADBEEF;
        tick();
        imem_rvalid = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rdw_drop: got valid=%b expected 0", out_valid); end
        if (imem_req !== 1'b1 || imem_addr !== 30'h100040) begin
            errors++;
            $display("[TB] FAIL rdw_target: got req=%b addr=%h expected 1/100040", imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h12345678;
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pc_plus4 !== 30'h100041 || out_inst !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL rdw_first: got %b/%h/%h expected 1/100041/12345678", out_valid, out_pc_plus4, out_inst);
        end
    endtask

    task automatic test_redirect_edges();
        settle();
        manual      = 1'b1;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 30'h200000;
        tick();
        redirect = 1'b0;
        imem_gnt = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rdg_discard: got req=%b valid=%b expected 0/0", imem_req, out_valid);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0BAD0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 30'h200000) begin
            errors++;
            $display("[TB] FAIL rdg_stale: got valid=%b req=%b addr=%h expected 0/1/200000", out_valid, imem_req, imem_addr);
        end
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 30'h200000) begin
            errors++;
            $display("[TB] FAIL rdg_rvalid_in_req: got valid=%b req=%b addr=%h expected 0/1/200000", out_valid, imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 30'h300000;
        tick();
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 30'h300000) begin
            errors++;
            $display("[TB] FAIL rdg_with_rvalid: got valid=%b req=%b addr=%h expected 0/1/300000", out_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_gnt_hold();
        logic [29:0] hold;
        settle();
        manual      = 1'b1;
        imem_rvalid = 1'b0;
        hold        = mpc;
        for (int i = 0; i < 3; i++) begin
            imem_gnt = 1'b0;
            tick();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== hold) begin
                errors++;
                $display("[TB] FAIL hold%0d: got req=%b addr=%h expected 1/%h", i, imem_req, imem_addr, hold);
            end
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL hold_wait: got req=%b expected 0", imem_req); end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE0001;
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== hold + 30'd1) begin
            errors++;
            $display("[TB] FAIL hold_advance: got req=%b addr=%h expected 1/%h", imem_req, imem_addr, hold + 30'd1);
        end
    endtask

    task automatic test_random();
        int idle_run = 0;
        manual  = 1'b0;
        gnt_pct = 60;
        lat_max = 3;
        for (int i = 0; i < 600; i++) begin
            stall    = ($urandom_range(99) < 30);
            redirect = ($urandom_range(99) < 4);
            if ($urandom_range(3) == 0) redirect_pc = 30'h3FFFFFFE;
            else                        redirect_pc = 30'($urandom());
            tick();
            redirect = 1'b0;
            checks++;
            if (out_valid !== (q.size() != 0)) begin
                errors++;
                $display("[TB] FAIL rnd_valid: cycle %0d got %b expected %b", i, out_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                checks++;
                if ({out_inst, out_pc_plus4} !== q[0]) begin
                    errors++;
                    $display("[TB] FAIL rnd_head: cycle %0d got %h/%h expected %h/%h", i, out_inst, out_pc_plus4, q[0][61:30], q[0][29:0]);
                end
            end
            if (imem_req) begin
                checks++;
                if (imem_addr !== mpc || outstanding || q.size() >= DEPTH) begin
                    errors++;
                    $display("[TB] FAIL rnd_req: cycle %0d got addr=%h expected %h (outstanding=%b count=%0d)", i, imem_addr, mpc, outstanding, q.size());
                end
            end
            if (expect_req) begin
                checks++;
                if (imem_req !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL rnd_redirect_latency: cycle %0d got req=%b expected 1", i, imem_req);
                end
            end
            if (!imem_req && !outstanding && q.size() < DEPTH) idle_run++;
            else                                               idle_run = 0;
            checks++;
            if (idle_run > 1) begin
                errors++;
                $display("[TB] FAIL rnd_liveness: cycle %0d got %0d idle cycles expected at most 1", i, idle_run);
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        manual      = 1'b0;
        gnt_pct     = 100;
        lat_max     = 3;
        stall       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = RESET_PC + 30'h50;
        tick();
        redirect = 1'b0;
        stall    = 1'b1;
        while (!(q.size() == 3 && outstanding) && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (!(q.size() == 3 && outstanding)) begin
            errors++;
            $display("[TB] FAIL rmid_setup: got count=%0d outstanding=%b expected 3/1", q.size(), outstanding);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rmid_reset: got valid=%b req=%b expected 0/0", out_valid, imem_req);
        end
        reset = 1'b1;
        stall = 1'b0;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 30'h100000 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rmid_restart: got req=%b addr=%h valid=%b expected 1/100000/0", imem_req, imem_addr, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_edges();
        test_gnt_hold();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
